sram_word_serializer: RTL and testbench

Buffers 32-bit readout words from the round-robin readout arbiter and presents them to the SRAM FIFO write port as two 16-bit halves, low half first. It sits in the BUS_CLK domain directly downstream of the arbiter. It decouples arbiter grants from SRAM write stalls with a small FIFO. It also provides a completed-word counter and a sticky overflow flag for monitoring.

---
 rtl/sram_word_serializer.sv | 186 ++++++++++++++++++
 tb/tb_sram_word_serializer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_word_serializer.sv
// Buffers 32-bit arbiter words in a small FIFO and hands them to the SRAM
// write port as two 16-bit halves, low half first, with a word counter and a sticky overflow flag.
module sram_word_serializer #(
  parameter int ABITS = 2
) (
  input  logic             BUS_CLK,
  input  logic             BUS_RST,
  input  logic             CLEAR,
  input  logic             WRITE_IN,
  input  logic [31:0]      DATA_IN,
  output logic             READY_OUT,
  output logic             HALF_VALID,
  output logic [15:0]      HALF_DATA,
  input  logic             HALF_READY,
  output logic [ABITS:0]   FILL_LEVEL,
  output logic [31:0]      WORD_COUNT,
  output logic             OVERFLOW
);

  localparam int DEPTH = 2 ** ABITS;
  localparam logic [ABITS:0]   FILL_FULL = (ABITS + 1)'(DEPTH);
  localparam logic [ABITS:0]   FILL_ZERO = (ABITS + 1)'(0);
  localparam logic [ABITS:0]   FILL_ONE  = (ABITS + 1)'(1);
  localparam logic [ABITS-1:0] PTR_ZERO  = ABITS'(0);
  localparam logic [ABITS-1:0] PTR_ONE   = ABITS'(1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_LOW   = 2'd1,
    S_HIGH  = 2'd2
  } state_t;

  logic [31:0]      mem_r [DEPTH];
  logic [ABITS-1:0] wr_ptr_r;
  logic [ABITS-1:0] rd_ptr_r;
  logic [ABITS:0]   fill_r;
  state_t           state_r;
  logic [31:0]      word_r;
  logic             half_valid_r;
  logic [15:0]      half_data_r;
  logic [31:0]      word_count_r;
  logic             overflow_r;

  logic             ready_s;
  logic             push_s;
  logic             pop_s;
  logic             count_inc_s;
  logic [31:0]      head_s;
  state_t           state_next_s;
  logic             half_valid_next_s;
  logic [15:0]      half_data_next_s;

  // No pass-through when full: a pop in the same cycle does not free a slot yet.
  assign ready_s    = (fill_r != FILL_FULL) & ~CLEAR;
  assign push_s     = WRITE_IN & ready_s;
  assign head_s     = mem_r[rd_ptr_r];

  assign READY_OUT  = ready_s;
  assign HALF_VALID = half_valid_r;
  assign HALF_DATA  = half_data_r;
  assign FILL_LEVEL = fill_r;
  assign WORD_COUNT = word_count_r;
  assign OVERFLOW   = overflow_r;

  // Serializer next-state, pop request and next half-word.
  always_comb begin
    state_next_s      = state_r;
    half_valid_next_s = half_valid_r;
    half_data_next_s  = half_data_r;
    pop_s             = 1'b0;
    count_inc_s       = 1'b0;
    case (state_r)
      S_EMPTY: begin
        if (fill_r != FILL_ZERO) begin
          pop_s             = 1'b1;
          half_valid_next_s = 1'b1;
          half_data_next_s  = head_s[15:0];
          state_next_s      = S_LOW;
        end else begin
          half_valid_next_s = 1'b0;
        end
      end
      S_LOW: begin
        if (HALF_READY) begin
          half_data_next_s = word_r[31:16];
          state_next_s     = S_HIGH;
        end else begin
          state_next_s     = S_LOW;
        end
      end
      S_HIGH: begin
        if (HALF_READY) begin
          count_inc_s = 1'b1;
          // Chain straight into the next word so the stream has no bubble.
          if (fill_r != FILL_ZERO) begin
            pop_s            = 1'b1;
            half_data_next_s = head_s[15:0];
            state_next_s     = S_LOW;
          end else begin
            half_valid_next_s = 1'b0;
            state_next_s      = S_EMPTY;
          end
        end else begin
          state_next_s = S_HIGH;
        end
      end
      default: begin
        half_valid_next_s = 1'b0;
        state_next_s      = S_EMPTY;
      end
    endcase
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge BUS_CLK) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= DATA_IN;
    end
  end

  // FIFO pointers and fill level.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      fill_r   <= FILL_ZERO;
    end else if (CLEAR) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      fill_r   <= FILL_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   fill_r <= fill_r + FILL_ONE;
        2'b01:   fill_r <= fill_r - FILL_ONE;
        default: fill_r <= fill_r;
      endcase
    end
  end

  // Serializer state, holding word and registered half-word outputs.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state_r      <= S_EMPTY;
      word_r       <= 32'd0;
      half_valid_r <= 1'b0;
      half_data_r  <= 16'd0;
    end else if (CLEAR) begin
      state_r      <= S_EMPTY;
      word_r       <= 32'd0;
      half_valid_r <= 1'b0;
      half_data_r  <= 16'd0;
    end else begin
      state_r      <= state_next_s;
      half_valid_r <= half_valid_next_s;
      half_data_r  <= half_data_next_s;
      if (pop_s) begin
        word_r <= head_s;
      end
    end
  end

  // Completed-word counter and sticky overflow flag.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      word_count_r <= 32'd0;
      overflow_r   <= 1'b0;
    end else if (CLEAR) begin
      word_count_r <= 32'd0;
      overflow_r   <= 1'b0;
    end else begin
      if (count_inc_s) begin
        word_count_r <= word_count_r + 32'd1;
      end
      if (WRITE_IN & ~ready_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_word_serializer.sv
// Directed bench for sram_word_serializer: a queue of expected half-words is
// filled on accepted pushes and drained on each half-word transfer.
module tb_sram_word_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        wr;
  logic [31:0] din;
  logic        hr;
  logic        ready_out;
  logic        half_valid;
  logic [15:0] half_data;
  logic [2:0]  fill_level;
  logic [31:0] word_count;
  logic        overflow;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] exp_q[$];
  logic [31:0] exp_wc = 32'd0;
  logic        exp_ovf = 1'b0;
  logic        half_hi = 1'b0;
  int          cyc = 0;
  int          tx_cnt = 0;
  int          tx_first = -1;
  int          tx_last = -1;
  int          pushed;
  logic        dropped;

  sram_word_serializer #(.ABITS(2)) dut (
    .BUS_CLK    (clk),
    .BUS_RST    (rst),
    .CLEAR      (clr),
    .WRITE_IN   (wr),
    .DATA_IN    (din),
    .READY_OUT  (ready_out),
    .HALF_VALID (half_valid),
    .HALF_DATA  (half_data),
    .HALF_READY (hr),
    .FILL_LEVEL (fill_level),
    .WORD_COUNT (word_count),
    .OVERFLOW   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, score the upcoming edge, then check counters after it.
  task automatic cycle(input logic w, input logic [31:0] d, input logic h, input logic c, input logic gate);
    logic [15:0] e;
    @(negedge clk);
    wr  = gate ? (w & ready_out) : w;
    din = d;
    hr  = h;
    clr = c;
    #1;
    if (clr) begin
      exp_q.delete();
      exp_wc  = 32'd0;
      exp_ovf = 1'b0;
      half_hi = 1'b0;
    end else begin
      if (half_valid && hr) begin
        if (exp_q.size() == 0) begin
          chk("half_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("half_data", {16'd0, half_data}, {16'd0, e});
          tx_cnt++;
          if (tx_first < 0) tx_first = cyc;
          tx_last = cyc;
          if (half_hi) exp_wc = exp_wc + 32'd1;
          half_hi = ~half_hi;
        end
      end
      if (wr && ready_out) begin
        exp_q.push_back(din[15:0]);
        exp_q.push_back(din[31:16]);
      end
      if (wr && !ready_out) exp_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("word_count", word_count, exp_wc);
    chk("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
  endtask

  task automatic drain(input int limit);
    int k = 0;
    while ((exp_q.size() != 0 || half_valid) && k < limit) begin
      cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      k++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("drain_idle", {31'd0, half_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; wr = 1'b0; din = 32'd0; hr = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", {31'd0, ready_out}, 32'd1);
    chk("rst_valid", {31'd0, half_valid}, 32'd0);
    chk("rst_data", {16'd0, half_data}, 32'd0);
    chk("rst_fill", {29'd0, fill_level}, 32'd0);
    chk("rst_wc", word_count, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single word and first-word latency.
    cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    chk("sw_fill", {29'd0, fill_level}, 32'd1);
    chk("sw_valid0", {31'd0, half_valid}, 32'd0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("sw_valid1", {31'd0, half_valid}, 32'd1);
    chk("sw_low", {16'd0, half_data}, 32'h0000_BEEF);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("sw_high", {16'd0, half_data}, 32'h0000_DEAD);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("sw_valid_end", {31'd0, half_valid}, 32'd0);
    chk("sw_wc", word_count, 32'd1);

    // Back-to-back pushes into a 4-deep FIFO.
    cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    chk("clr_ready", {31'd0, ready_out}, 32'd0);
    chk("clr_fill", {29'd0, fill_level}, 32'd0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    pushed = 0; dropped = 1'b0; tx_cnt = 0; tx_first = -1; tx_last = -1;
    for (int k = 0; k < 60 && (pushed < 8 || exp_q.size() != 0 || half_valid); k++) begin
      if (pushed < 8 && !ready_out) dropped = 1'b1;
      cycle(pushed < 8, 32'h0001_0000 + 32'(pushed), 1'b1, 1'b0, 1'b1);
      if (wr) pushed++;
    end
    chk("b2b_pushed", 32'(pushed), 32'd8);
    chk("b2b_ready_drop", {31'd0, dropped}, 32'd1);
    chk("b2b_halves", 32'(tx_cnt), 32'd16);
    chk("b2b_no_bubble", 32'(tx_last - tx_first), 32'd15);
    chk("b2b_wc", word_count, 32'd8);

    // Stall mid-word while the FIFO fills, then overflow.
    cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 32'hA000_0000 + 32'(k), 1'b0, 1'b0, 1'b1);
      chk("stall_data", {16'd0, half_data}, 32'h0000_DEAD);
      chk("stall_valid", {31'd0, half_valid}, 32'd1);
    end
    chk("stall_fill", {29'd0, fill_level}, 32'd4);
    chk("stall_ready", {31'd0, ready_out}, 32'd0);
    cycle(1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_fill", {29'd0, fill_level}, 32'd4);
    drain(40);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("ovf_clr", {31'd0, overflow}, 32'd0);
    chk("ovf_clr_fill", {29'd0, fill_level}, 32'd0);

    // Asynchronous reset in HIGH with three words queued.
    cycle(1'b1, 32'h5A5A_A5A5, 1'b1, 1'b0, 1'b0);
    drain(10);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 32'hC0DE_1000 + 32'(k), 1'b0, 1'b0, 1'b1);
    end
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_fill", {29'd0, fill_level}, 32'd3);
    chk("pre_rst_high", {16'd0, half_data}, 32'h0000_C0DE);
    chk("pre_rst_wc", word_count, 32'd1);
    @(negedge clk);
    hr = 1'b0; wr = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, half_valid}, 32'd0);
    chk("arst_data", {16'd0, half_data}, 32'd0);
    chk("arst_fill", {29'd0, fill_level}, 32'd0);
    chk("arst_wc", word_count, 32'd0);
    chk("arst_ready", {31'd0, ready_out}, 32'd1);
    exp_q.delete(); exp_wc = 32'd0; exp_ovf = 1'b0; half_hi = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    drain(10);
    chk("post_rst_wc", word_count, 32'd1);

    // Counter wrap from the all-ones value.
    force dut.word_count_r = 32'hFFFF_FFFF;
    #1;
    release dut.word_count_r;
    exp_wc = 32'hFFFF_FFFF;
    cycle(1'b1, 32'h0F0F_F0F0, 1'b1, 1'b0, 1'b0);
    drain(10);
    chk("wrap_wc", word_count, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
